// File: rtl/rsa_pkg.sv
// Shared RSA constants and the sequencing state type used by the RSA datapath blocks.
package rsa_pkg;

  localparam int RSA_W = 256;
  localparam int CNT_W = 9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mod_double.sv
// Reduced doubling: returns (2t or t) mod N for inputs already below 2N.
module mod_double
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic [W-1:0] i_t,
  input  logic [W-1:0] i_n,
  input  logic         i_dbl,
  output logic [W-1:0] o_r
);

  logic [W:0]   w_d;
  logic [W:0]   w_n_ext;
  logic [W-1:0] w_sub_lo;
  logic         w_unused_sub_msb;

  // One guard bit keeps the carry out of the doubling visible to the compare.
  assign w_d     = i_dbl ? {i_t, 1'b0} : {1'b0, i_t};
  assign w_n_ext = {1'b0, i_n};
  assign {w_unused_sub_msb, w_sub_lo} = w_d - w_n_ext;
  assign o_r = (w_d >= w_n_ext) ? w_sub_lo : w_d[W-1:0];

endmodule

// File: rtl/mod_product.sv
// Computes y*2^W mod N by W reduced doublings, producing the Montgomery-domain b operand.
//
// state | meaning
// IDLE  | waiting for i_start; operands latched on acceptance
// LOAD  | t <= y mod N (single conditional subtract), counter cleared
// RUN   | t <= 2t mod N once per cycle for W cycles
// DONE  | result published, one-cycle o_finished pulse
module mod_product
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [W-1:0] i_y,
  input  logic [W-1:0] i_n,
  output logic [W-1:0] o_result,
  output logic         o_finished,
  output logic         o_busy
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(W - 1);

  state_t           r_state;
  logic [W-1:0]     r_y;
  logic [W-1:0]     r_n;
  logic [W-1:0]     r_t;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_result;
  logic             r_finished;
  logic             r_busy;

  logic [W-1:0]     w_md_in;
  logic [W-1:0]     w_md_out;
  logic             w_dbl;

  // The same reducer serves LOAD (no doubling) and RUN (doubling).
  assign w_md_in = (r_state == S_LOAD) ? r_y : r_t;
  assign w_dbl   = (r_state == S_RUN);

  mod_double #(.W(W)) u_mod_double (
    .i_t   (w_md_in),
    .i_n   (r_n),
    .i_dbl (w_dbl),
    .o_r   (w_md_out)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= S_IDLE;
      r_y        <= '0;
      r_n        <= '0;
      r_t        <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_finished <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_y     <= i_y;
            r_n     <= i_n;
            r_busy  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_t     <= w_md_out;
          r_cnt   <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_t   <= w_md_out;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_STEP) begin
            r_result   <= w_md_out;
            r_finished <= 1'b1;
            r_state    <= S_DONE;
          end
        end
        S_DONE: begin
          r_finished <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: begin
          r_finished <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign o_result   = r_result;
  assign o_finished = r_finished;
  assign o_busy     = r_busy;

endmodule

// File: doc/mod_product.md
MOD_PRODUCT -- requirements
Module: mod_product

Interface
REQ-001 The block SHALL have one parameter: W, default 256, operand width in bits.
REQ-002 The block SHALL have port i_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port i_rst, input, 1, reset; one clock; reset is synchronous and active-low.
REQ-004 The block SHALL have port i_start, input, 1, start request; sampled only in IDLE.
REQ-005 The block SHALL have port i_y, input, W, operand y; captured at accepted start.
REQ-006 The block SHALL have port i_n, input, W, modulus N; odd and >1; captured at accepted start.
REQ-007 The block SHALL have port o_result, output, W, y*2^W mod N; feeds the Montgomery multiplier's b operand.
REQ-008 The block SHALL have port o_finished, output, 1, single-cycle done pulse.
REQ-009 The block SHALL have port o_busy, output, 1, high in every state except IDLE.

Function
REQ-010 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-011 Transitions SHALL be:
- IDLE->LOAD on i_start=1;
- LOAD->RUN unconditionally;
- RUN->DONE when the step counter equals W-1;
- DONE->IDLE unconditionally.
REQ-012 On IDLE->LOAD the block SHALL latch i_y and i_n; later input changes SHALL NOT affect the result.
REQ-013 LOAD SHALL set t = (y >= N) ? y-N : y; for y >= 2N the result is unspecified.
REQ-014 LOAD SHALL clear the 9-bit step counter to 0.
REQ-015 Each RUN cycle SHALL compute d = 2t in W+1 bits, then set t = (d >= N) ? d-N : d, and increment the counter.
REQ-016 After W RUN cycles t SHALL equal y*2^W mod N, which is always < N.
REQ-017 Comparison and subtraction SHALL be unsigned at W+1 bits; no carry SHALL be lost.
REQ-018 On DONE entry o_result SHALL take t.
REQ-019 o_result SHALL hold that value until the next DONE or until reset.
REQ-020 o_finished SHALL be 1 only in DONE, exactly one cycle per operation.
REQ-021 Latency: with i_start sampled at edge k, o_finished SHALL be high between edges k+257 and k+258 (W=256).
REQ-022 i_start SHALL be ignored in LOAD, RUN and DONE; no queuing.
REQ-023 i_start high in DONE SHALL be ignored.
REQ-024 i_start held high continuously SHALL start a new operation on the first IDLE cycle after DONE.

Reset
REQ-025 With i_rst=0 at a rising edge, the block SHALL enter IDLE.
REQ-026 That same reset edge SHALL set o_result=0, o_finished=0, o_busy=0, counter=0, t=0 and latched operands=0.
REQ-027 Reset mid-operation SHALL abort it without any o_finished pulse.
REQ-028 Reset SHALL take priority over i_start at the same edge.

Structure
REQ-029 Shared package rsa_pkg SHALL hold the width constant (256) and the state enum typedef, reused by montMul and the top-level RSA core.
REQ-030 One combinational sub-module, mod_double, SHALL implement REQ-015 (inputs t, N; output reduced 2t).
REQ-031 mod_double SHALL be reused for the conditional subtract in REQ-013 with the doubling bypassed.
REQ-032 No other sub-modules SHALL be used.

Verification
REQ-033 N=13, y=1, start -> o_result=3 with o_finished pulse at edge k+257.
REQ-034 N=13, y=12 -> o_result=10.
REQ-035 N=13, y=0 -> o_result=0.
REQ-036 N=13, y=14 (y >= N, LOAD reduction) -> o_result=3.
REQ-037 N=2^256-189, y=1 -> o_result=189.
REQ-038 Start y=1, N=13; pulse i_start again at RUN step 100 and change i_y/i_n -> result still 3, single o_finished.
REQ-039 i_rst=0 at RUN step 50 -> next cycle o_busy=0, o_result=0, no o_finished; a new start then completes correctly.
